// File: rtl/seq_scan_pkg.sv
// Shared types and reset-time configuration for the serial pattern-scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] DEF_PATTERN = 8'b0000_1100;
  localparam logic [3:0] DEF_LEN     = 4'd4;
  localparam logic       DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_scan_ctrl_match.sv
// Bit-serial matcher: history shift register, fill counter, masked pattern
// compare and non-overlap restart. hit is combinational for the current bit.
module seq_match_unit #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          bit_in,
  input  logic          bit_vld,
  input  logic [PW-1:0] cfg_pattern,
  input  logic [3:0]    cfg_len,
  input  logic          cfg_overlap,
  output logic          hit
);

  localparam logic [3:0] PW_L = 4'(PW);

  logic [PW-1:0] hist_q, hist_d, hist_next, mask;
  logic [3:0]    fill_q, fill_d, fill_next;

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_mask
      assign mask[gi] = (4'(gi) < cfg_len);
    end
  endgenerate

  assign hist_next = {hist_q[PW-2:0], bit_in};
  assign fill_next = (fill_q >= PW_L) ? PW_L : fill_q + 4'd1;
  assign hit       = bit_vld && (fill_next >= cfg_len) &&
                     (((hist_next ^ cfg_pattern) & mask) == '0);

  // Without overlap the fill restarts, so stale history bits never re-qualify.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_vld) begin
      hist_d = hist_next;
      fill_d = (hit && !cfg_overlap) ? 4'd0 : fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan-job controller: accepts words over valid/ready, serializes MSB first
// into the matcher and counts matches until the last word or an abort.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pattern,
  input  logic [3:0]    cfg_len,
  input  logic          cfg_overlap,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          busy,
  output logic          match_pulse,
  output logic [CW-1:0] match_count,
  output logic          done,
  output logic          err_cfg
);

  localparam int         BW   = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [3:0] PW_L = 4'(PW);

  state_e        state_q, state_d;
  logic [DW-1:0] word_q, word_d;
  logic          last_q, last_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          pulse_q, pulse_d;
  logic          err_q, err_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [3:0]    len_q, len_d;
  logic          ov_q, ov_d;

  logic [3:0]    len_eff;
  logic          len_ok;
  logic          clr, bit_vld, hit;

  // A config write in the same cycle as start is what start validates.
  assign len_eff = cfg_we ? cfg_len : len_q;
  assign len_ok  = (len_eff != 4'd0) && (len_eff <= PW_L);

  seq_match_unit #(.PW(PW)) u_match (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .bit_in      (word_q[DW-1]),
    .bit_vld     (bit_vld),
    .cfg_pattern (pat_q),
    .cfg_len     (len_q),
    .cfg_overlap (ov_q),
    .hit         (hit)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    pulse_d   = 1'b0;
    err_d     = 1'b0;
    pat_d     = pat_q;
    len_d     = len_q;
    ov_d      = ov_q;
    clr       = 1'b0;
    bit_vld   = 1'b0;
    s_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          ov_d  = cfg_overlap;
        end
        if (start) begin
          if (len_ok) begin
            clr     = 1'b1;
            count_d = '0;
            state_d = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        s_ready = !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          word_d    = s_data;
          last_d    = s_last;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The bit presented during an abort cycle is dropped, so it cannot count.
        if (abort) begin
          state_d = IDLE;
        end else begin
          bit_vld   = 1'b1;
          word_d    = {word_q[DW-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DW - 1)) begin
            state_d = last_q ? DONE : FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (hit) begin
      pulse_d = 1'b1;
      if (count_q != '1) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
      pat_q     <= PW'(DEF_PATTERN);
      len_q     <= DEF_LEN;
      ov_q      <= DEF_OVERLAP;
    end else begin
      word_q    <= word_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ov_q      <= ov_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign match_pulse = pulse_q;
  assign match_count = count_q;
  assign err_cfg     = err_q;
  assign done        = (state_q == DONE) && !abort;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: per-job expected counts are queued at
// stimulus time and checked when the DUT signals done.
module tb_seq_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       start;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready, busy, match_pulse, done, err_cfg;
  logic [7:0] match_count;
  logic       s_ready2, busy2, match_pulse2, done2, err_cfg2;
  logic [1:0] match_count2;

  int tests = 0;
  int fails = 0;
  int mon_pulses = 0;
  int exp_cnt_q[$];
  int exp_pulse_q[$];

  seq_scan_ctrl #(.DW(8), .PW(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .busy(busy), .match_pulse(match_pulse), .match_count(match_count),
    .done(done), .err_cfg(err_cfg)
  );

  seq_scan_ctrl #(.DW(8), .PW(8), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready2),
    .busy(busy2), .match_pulse(match_pulse2), .match_count(match_count2),
    .done(done2), .err_cfg(err_cfg2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pop the expected job result when the primary DUT reports done.
  always @(negedge clk) begin
    int e, p;
    if (rst || !busy) begin
      mon_pulses = 0;
    end else begin
      if (match_pulse) mon_pulses++;
      if (done) begin
        tests++;
        if (exp_cnt_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: count=%0d, no job expected", match_count);
        end else begin
          e = exp_cnt_q.pop_front();
          p = exp_pulse_q.pop_front();
          if (match_count !== 8'(e) || mon_pulses != p) begin
            fails++;
            $display("FAIL job_result: count=%0d pulses=%0d, expected count=%0d pulses=%0d",
                     match_count, mon_pulses, e, p);
          end else begin
            $display("[TB] job done count=%0d pulses=%0d", match_count, mon_pulses);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_job(input logic with_cfg, input logic [7:0] p,
                           input logic [3:0] l, input logic ov);
    start = 1'b1; cfg_we = with_cfg; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!s_ready) begin
      fails++;
      $display("FAIL send_word_ready: s_ready=%0b after %0d cycles, expected 1", s_ready, n);
    end
    @(posedge clk); #1;
    $display("[TB] word sent data=%02h last=%0b", d, l);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL wait_done: done=%0b after %0d cycles, expected 1", done, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({busy, s_ready, match_pulse, done, err_cfg} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: busy/rdy/pulse/done/err=%05b, expected 00000",
               {busy, s_ready, match_pulse, done, err_cfg});
    end
    tests++;
    if (match_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_count: count=%0d, expected 0", match_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_default();
    logic [9:0] pm, dm;
    pm = '0; dm = '0;
    exp_cnt_q.push_back(2); exp_pulse_q.push_back(2);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'hCC, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pm[k] = match_pulse;
      dm[k] = done;
    end
    tests++;
    if (pm !== 10'b01_0001_0000) begin
      fails++;
      $display("FAIL default_pulse_timing: pulses=%010b, expected 0100010000", pm);
    end
    tests++;
    if (dm !== 10'b01_0000_0000) begin
      fails++;
      $display("FAIL default_done_timing: done=%010b, expected 0100000000", dm);
    end
    tests++;
    if (busy !== 1'b0 || match_count !== 8'd2) begin
      fails++;
      $display("FAIL default_end: busy=%0b count=%0d, expected busy=0 count=2", busy, match_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overlap();
    cfg_write(8'b0000_0101, 4'd3, 1'b1);
    exp_cnt_q.push_back(2); exp_pulse_q.push_back(2);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'b1010_1000, 1'b1);
    wait_done();
    tests++;
    if (match_count !== 8'd2) begin
      fails++;
      $display("FAIL overlap_on: count=%0d, expected 2", match_count);
    end
    cfg_write(8'b0000_0101, 4'd3, 1'b0);
    exp_cnt_q.push_back(1); exp_pulse_q.push_back(1);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'b1010_1000, 1'b1);
    wait_done();
    tests++;
    if (match_count !== 8'd1) begin
      fails++;
      $display("FAIL overlap_off: count=%0d, expected 1", match_count);
    end
  endtask

  task automatic test_stall();
    cfg_write(8'h0C, 4'd4, 1'b1);
    exp_cnt_q.push_back(1); exp_pulse_q.push_back(1);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'h03, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (s_ready !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall_fetch[%0d]: s_ready=%0b busy=%0b, expected 1 1", i, s_ready, busy);
      end
      @(posedge clk); #1;
    end
    send_word(8'h00, 1'b1);
    wait_done();
    tests++;
    if (match_count !== 8'd1) begin
      fails++;
      $display("FAIL stall_history: count=%0d, expected 1", match_count);
    end
  endtask

  task automatic test_cfg_err();
    cfg_write(8'h0C, 4'd0, 1'b1);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    tests++;
    if (err_cfg !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL err_len0: err=%0b busy=%0b rdy=%0b, expected 1 0 0", err_cfg, busy, s_ready);
    end
    @(negedge clk);
    tests++;
    if (err_cfg !== 1'b0) begin
      fails++;
      $display("FAIL err_one_cycle: err=%0b, expected 0", err_cfg);
    end
    @(posedge clk); #1;
    start_job(1'b1, 8'h0C, 4'd9, 1'b1);
    @(negedge clk);
    tests++;
    if (err_cfg !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_len9_same_cycle: err=%0b busy=%0b, expected 1 0", err_cfg, busy);
    end
    @(posedge clk); #1;
    exp_cnt_q.push_back(2); exp_pulse_q.push_back(2);
    start_job(1'b1, 8'h0C, 4'd4, 1'b1);
    tests++;
    if (err_cfg !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_with_cfg: err=%0b busy=%0b, expected 0 1", err_cfg, busy);
    end
    cfg_write(8'h01, 4'd2, 1'b1);
    send_word(8'hCC, 1'b1);
    wait_done();
    tests++;
    if (match_count !== 8'd2) begin
      fails++;
      $display("FAIL cfg_while_busy: count=%0d, expected 2", match_count);
    end
  endtask

  task automatic test_abort();
    logic seen_done;
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    s_valid = 1'b1; s_data = 8'hCC; s_last = 1'b1; abort = 1'b1;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_fetch_ready: s_ready=%0b, expected 0", s_ready);
    end
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_fetch_idle: busy=%0b rdy=%0b done=%0b, expected 0 0 0", busy, s_ready, done);
    end
    @(posedge clk); #1;

    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'hCC, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || match_count !== 8'd0) begin
      fails++;
      $display("FAIL abort_shift3: busy=%0b count=%0d, expected 0 0", busy, match_count);
    end
    seen_done = done;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_done |= done;
    end
    tests++;
    if (seen_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: done seen=%0b, expected 0", seen_done);
    end
    @(posedge clk); #1;

    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'hCC, 1'b1);
    repeat (7) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || match_pulse !== 1'b0 || match_count !== 8'd1 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_last_bit: busy=%0b pulse=%0b count=%0d done=%0b, expected 0 0 1 0",
               busy, match_pulse, match_count, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int p2 = 0;
    int n = 0;
    cfg_write(8'h01, 4'd1, 1'b1);
    exp_cnt_q.push_back(8); exp_pulse_q.push_back(8);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'hFF, 1'b1);
    do begin
      @(negedge clk);
      if (match_pulse2) p2++;
      n++;
    end while (!done2 && n < 50);
    tests++;
    if (p2 != 8 || match_count2 !== 2'd3) begin
      fails++;
      $display("FAIL saturate_cw2: pulses=%0d count=%0d, expected 8 3", p2, match_count2);
    end
    @(posedge clk); #1;
    tests++;
    if (match_count !== 8'd8) begin
      fails++;
      $display("FAIL count_len1: count=%0d, expected 8", match_count);
    end
  endtask

  task automatic test_midjob_reset();
    cfg_write(8'b0000_0101, 4'd3, 1'b0);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'b1010_1000, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || match_count !== 8'd0) begin
      fails++;
      $display("FAIL midjob_reset: busy=%0b count=%0d, expected 0 0", busy, match_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt_q.push_back(2); exp_pulse_q.push_back(2);
    start_job(1'b0, 8'h00, 4'd0, 1'b0);
    send_word(8'hCC, 1'b1);
    wait_done();
    tests++;
    if (match_count !== 8'd2) begin
      fails++;
      $display("FAIL reset_default_cfg: count=%0d, expected 2", match_count);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_stall();
    test_cfg_err();
    test_abort();
    test_saturate();
    test_midjob_reset();
    repeat (3) @(posedge clk);
    tests++;
    if (exp_cnt_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d jobs pending, expected 0", exp_cnt_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
